// File: rtl/mips_instr_encoder.sv
// Encodes decoded MIPS commands into sequential instruction-memory writes, one registered word per command (li: two).
// Backpressure: cmd_ready drops during reset/clear, while the li low word is pending, and once memory is full.
module mips_instr_encoder #(
   parameter int unsigned ADDR_W    = 8,
   parameter logic [31:0] BASE_ADDR = 32'h00400000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [4:0]        cmd_op,
   input  logic [4:0]        cmd_rs,
   input  logic [4:0]        cmd_rt,
   input  logic [4:0]        cmd_rd,
   input  logic [4:0]        cmd_shamt,
   input  logic [31:0]       cmd_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic [ADDR_W:0]   words_written,
   output logic              full,
   output logic              err_valid,
   output logic [2:0]        err_code
);
   localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] LAST_PTR = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [0:0] {IDLE, LI_LO} state_t;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] loWord;
      logic        isLi;
      logic [2:0]  errCode;
   } enc_t;

   state_t          state, stateNext;
   enc_t            enc;
   logic [ADDR_W:0] ptr;
   logic [31:0]     pendingLo;
   logic [29:0]     pcNextWord;
   logic [29:0]     diffWords;
   logic            misaligned, offsetOk, regionOk, accept;
   logic [5:0]      funct, opcode;
   logic [2:0]      brErr, jmpErr, liErr;

   function automatic logic [5:0] functOf(input logic [4:0] op);
      case (op)
         5'd0:    functOf = 6'h20;
         5'd1:    functOf = 6'h21;
         5'd2:    functOf = 6'h22;
         5'd3:    functOf = 6'h23;
         5'd4:    functOf = 6'h24;
         5'd5:    functOf = 6'h25;
         5'd6:    functOf = 6'h26;
         5'd7:    functOf = 6'h27;
         5'd8:    functOf = 6'h2a;
         5'd9:    functOf = 6'h2b;
         5'd11:   functOf = 6'h02;
         5'd12:   functOf = 6'h03;
         5'd13:   functOf = 6'h08;
         5'd14:   functOf = 6'h09;
         default: functOf = 6'h00;
      endcase
   endfunction

   function automatic logic [5:0] opcodeOf(input logic [4:0] op);
      case (op)
         5'd15:   opcodeOf = 6'h0f;
         5'd16:   opcodeOf = 6'h08;
         5'd17:   opcodeOf = 6'h09;
         5'd18:   opcodeOf = 6'h0c;
         5'd19:   opcodeOf = 6'h0d;
         5'd20:   opcodeOf = 6'h0a;
         5'd21:   opcodeOf = 6'h0b;
         5'd22:   opcodeOf = 6'h23;
         5'd23:   opcodeOf = 6'h2b;
         5'd24:   opcodeOf = 6'h04;
         5'd25:   opcodeOf = 6'h05;
         5'd26:   opcodeOf = 6'h06;
         5'd27:   opcodeOf = 6'h07;
         5'd28:   opcodeOf = 6'h01;
         5'd29:   opcodeOf = 6'h02;
         5'd30:   opcodeOf = 6'h03;
         default: opcodeOf = 6'h00;
      endcase
   endfunction

   assign funct  = functOf(cmd_op);
   assign opcode = opcodeOf(cmd_op);

   // Branch/jump arithmetic in word units; the base is word aligned so the low byte bits never borrow.
   assign pcNextWord = BASE_ADDR[31:2] + 30'(ptr) + 30'd1;
   assign diffWords  = cmd_imm[31:2] - pcNextWord;
   assign misaligned = cmd_imm[1:0] != 2'b00;
   assign offsetOk   = (diffWords[29:15] == '0) || (diffWords[29:15] == '1);
   assign regionOk   = cmd_imm[31:28] == pcNextWord[29:26];

   assign brErr  = misaligned ? 3'd2 : (!offsetOk ? 3'd1 : 3'd0);
   assign jmpErr = misaligned ? 3'd2 : (!regionOk ? 3'd3 : 3'd0);
   assign liErr  = (ptr == LAST_PTR) ? 3'd4 : 3'd0;

   always_comb begin
      enc = '0;
      case (cmd_op)
         5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9:
            enc.word = {6'h00, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, funct};
         5'd10, 5'd11, 5'd12:
            enc.word = {6'h00, 5'd0, cmd_rt, cmd_rd, cmd_shamt, funct};
         5'd13:
            enc.word = {6'h00, cmd_rs, 15'd0, funct};
         5'd14:
            enc.word = {6'h00, cmd_rs, 5'd0, cmd_rd, 5'd0, funct};
         5'd15:
            enc.word = {opcode, 5'd0, cmd_rt, cmd_imm[15:0]};
         5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23:
            enc.word = {opcode, cmd_rs, cmd_rt, cmd_imm[15:0]};
         5'd24, 5'd25: begin
            enc.word    = {opcode, cmd_rs, cmd_rt, diffWords[15:0]};
            enc.errCode = brErr;
         end
         5'd26, 5'd27, 5'd28: begin
            enc.word    = {opcode, cmd_rs, 5'd0, diffWords[15:0]};
            enc.errCode = brErr;
         end
         5'd29, 5'd30: begin
            enc.word    = {opcode, cmd_imm[27:2]};
            enc.errCode = jmpErr;
         end
         default: begin
            enc.word    = {6'h0f, 5'd0, cmd_rt, cmd_imm[31:16]};
            enc.loWord  = {6'h0d, cmd_rt, cmd_rt, cmd_imm[15:0]};
            enc.isLi    = 1'b1;
            enc.errCode = liErr;
         end
      endcase
   end

   assign full          = ptr == DEPTH;
   assign words_written = ptr;
   assign cmd_ready     = !reset && (state == IDLE) && !full && !clear;
   assign accept        = cmd_valid && cmd_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (accept && enc.isLi && enc.errCode == 3'd0) stateNext = LI_LO;
         LI_LO:   stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
      if (clear) stateNext = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr        <= '0;
         pendingLo  <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         err_valid  <= 1'b0;
         err_code   <= 3'd0;
      end else begin
         imem_we   <= 1'b0;
         err_valid <= 1'b0;
         if (clear) begin
            ptr <= '0;
         end else if (state == LI_LO) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr[ADDR_W-1:0];
            imem_wdata <= pendingLo;
            ptr        <= ptr + ONE;
         end else if (accept) begin
            if (enc.errCode != 3'd0) begin
               err_valid <= 1'b1;
               err_code  <= enc.errCode;
            end else begin
               imem_we    <= 1'b1;
               imem_addr  <= ptr[ADDR_W-1:0];
               imem_wdata <= enc.word;
               ptr        <= ptr + ONE;
               if (enc.isLi) pendingLo <= enc.loWord;
            end
         end
      end
   end
endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: directed plan steps plus random commands against a queue-based reference model.
module tb_mips_instr_encoder;
   localparam logic [31:0] BASE = 32'h00400000;

   logic        clk = 1'b0, reset = 1'b1, cmdValid = 1'b0, clr = 1'b0;
   bit          sel = 1'b0;
   logic [4:0]  op = '0, rs = '0, rt = '0, rd = '0, sh = '0;
   logic [31:0] imm = '0;

   logic        rdy8, we8, full8, ev8;
   logic [7:0]  addr8;
   logic [31:0] wd8;
   logic [8:0]  ww8;
   logic [2:0]  ec8;
   logic        rdy2, we2, full2, ev2;
   logic [1:0]  addr2;
   logic [31:0] wd2;
   logic [2:0]  ww2;
   logic [2:0]  ec2;

   logic        obsRdy, obsWe, obsFull, obsEv;
   logic [31:0] obsAddr, obsWdata, obsWw;
   logic [2:0]  obsEc;

   always #5 clk = ~clk;

   mips_instr_encoder #(.ADDR_W(8), .BASE_ADDR(BASE)) dut8 (
      .clk(clk), .reset(reset), .clear(clr && !sel), .cmd_valid(cmdValid && !sel), .cmd_ready(rdy8),
      .cmd_op(op), .cmd_rs(rs), .cmd_rt(rt), .cmd_rd(rd), .cmd_shamt(sh), .cmd_imm(imm),
      .imem_we(we8), .imem_addr(addr8), .imem_wdata(wd8), .words_written(ww8), .full(full8),
      .err_valid(ev8), .err_code(ec8));

   mips_instr_encoder #(.ADDR_W(2), .BASE_ADDR(BASE)) dut2 (
      .clk(clk), .reset(reset), .clear(clr && sel), .cmd_valid(cmdValid && sel), .cmd_ready(rdy2),
      .cmd_op(op), .cmd_rs(rs), .cmd_rt(rt), .cmd_rd(rd), .cmd_shamt(sh), .cmd_imm(imm),
      .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2), .words_written(ww2), .full(full2),
      .err_valid(ev2), .err_code(ec2));

   always_comb begin
      if (sel) begin
         obsRdy = rdy2; obsWe = we2; obsFull = full2; obsEv = ev2; obsEc = ec2;
         obsAddr = 32'(addr2); obsWdata = wd2; obsWw = 32'(ww2);
      end else begin
         obsRdy = rdy8; obsWe = we8; obsFull = full8; obsEv = ev8; obsEc = ec8;
         obsAddr = 32'(addr8); obsWdata = wd8; obsWw = 32'(ww8);
      end
   end

   int nCmp = 0, nErr = 0;
   logic [31:0] q[$];
   int mPtr = 0, mAddr = 0, mErr = 0;
   logic [31:0] mWdata = '0;

   logic [5:0] functTbl [0:14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                   6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};
   logic [5:0] opcTbl [0:15]   = '{6'h0f, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0a, 6'h0b, 6'h23,
                                   6'h2b, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01, 6'h02, 6'h03};

   function automatic int depth();
      return sel ? 4 : 256;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference encoding straight from the instruction tables and PC-relative arithmetic.
   function automatic void refEnc(input logic [4:0] o, a, b, d, s, input logic [31:0] im,
                                  input int p, input int dep,
                                  output logic [31:0] w0, output logic [31:0] w1,
                                  output int n, output int ec);
      logic [31:0] pc4;
      logic [4:0]  ra, rb, rdd, sa;
      int          diff;
      w0 = '0; w1 = '0; n = 1; ec = 0;
      pc4 = BASE + 32'(4 * p + 4);
      if (o <= 14) begin
         ra = a; rb = b; rdd = d; sa = s;
         if (o >= 10 && o <= 12) ra = 5'd0;
         if (o == 13) begin rb = 5'd0; rdd = 5'd0; sa = 5'd0; end
         if (o == 14) begin rb = 5'd0; sa = 5'd0; end
         w0 = {6'd0, ra, rb, rdd, sa, functTbl[o]};
      end else if (o <= 23) begin
         w0 = {opcTbl[o - 15], (o == 15) ? 5'd0 : a, b, im[15:0]};
      end else if (o <= 28) begin
         diff = int'(im - pc4);
         if (im % 4 != 0) ec = 2;
         else if (diff / 4 < -32768 || diff / 4 > 32767) ec = 1;
         else w0 = {opcTbl[o - 15], a, (o >= 26) ? 5'd0 : b, 16'(diff / 4)};
      end else if (o <= 30) begin
         if (im % 4 != 0) ec = 2;
         else if (im / 2**28 != pc4 / 2**28) ec = 3;
         else w0 = {opcTbl[o - 15], 26'(im / 4)};
      end else begin
         if (p == dep - 1) ec = 4;
         else begin
            w0 = {6'h0f, 5'd0, b, 16'(im / 65536)};
            w1 = {6'h0d, b, b, 16'(im % 65536)};
            n  = 2;
         end
      end
   endfunction

   task automatic setCmd(input int o, input int a, input int b, input int d, input int s, input logic [31:0] im);
      op = 5'(o); rs = 5'(a); rt = 5'(b); rd = 5'(d); sh = 5'(s); imm = im;
   endtask

   task automatic doReset();
      reset = 1'b1; cmdValid = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
      q.delete(); mPtr = 0; mAddr = 0; mWdata = '0; mErr = 0;
      chk("rst_cmd_ready", obsRdy, 0);
      chk("rst_imem_we", obsWe, 0);
      chk("rst_imem_addr", obsAddr, 0);
      chk("rst_imem_wdata", obsWdata, 0);
      chk("rst_words_written", obsWw, 0);
      chk("rst_full", obsFull, 0);
      chk("rst_err_valid", obsEv, 0);
      chk("rst_err_code", obsEc, 0);
      reset = 1'b0;
   endtask

   // One clock: present valid/clear, check readiness, then check every registered output after the edge.
   task automatic cyc(input bit v, input bit c);
      logic [31:0] w0, w1;
      int n, ec;
      bit acc, expRdy, expWe;
      cmdValid = v; clr = c;
      #1;
      expRdy = (q.size() == 0) && (mPtr < depth()) && !c;
      chk("cmd_ready", obsRdy, expRdy);
      acc = v && expRdy;
      w0 = '0; w1 = '0; n = 0; ec = 0;
      if (acc) refEnc(op, rs, rt, rd, sh, imm, mPtr, depth(), w0, w1, n, ec);
      @(posedge clk); #1;
      cmdValid = 1'b0; clr = 1'b0;
      expWe = 1'b0;
      if (c) begin
         q.delete();
         mPtr = 0;
      end else begin
         if (acc && ec != 0) mErr = ec;
         else if (acc) begin
            q.push_back(w0);
            if (n == 2) q.push_back(w1);
         end
         if (q.size() > 0) begin
            mWdata = q.pop_front();
            mAddr  = mPtr;
            mPtr++;
            expWe  = 1'b1;
         end
      end
      chk("imem_we", obsWe, expWe);
      chk("imem_addr", obsAddr, mAddr);
      chk("imem_wdata", obsWdata, mWdata);
      chk("words_written", obsWw, mPtr);
      chk("full", obsFull, mPtr == depth());
      chk("err_valid", obsEv, acc && ec != 0);
      chk("err_code", obsEc, mErr);
   endtask

   task automatic randCmd();
      logic [31:0] tgt;
      setCmd($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
      if (op >= 24 && op <= 30 && $urandom_range(0, 3) != 0) begin
         tgt = BASE + 32'(4 * mPtr + 4) + 32'(4 * ($urandom_range(0, 80000) - 40000));
         if ($urandom_range(0, 7) == 0) tgt = tgt + $urandom_range(1, 3);
         imm = tgt;
      end
   endtask

   initial begin
      sel = 1'b0;
      doReset();

      setCmd(0, 9, 10, 8, 0, 32'h0);
      cyc(1, 0);
      chk("add_wdata", obsWdata, 32'h012A4020);
      chk("add_addr", obsAddr, 0);
      chk("add_words", obsWw, 1);
      cyc(0, 1);

      setCmd(31, 0, 8, 0, 0, 32'h12345678);
      cyc(1, 0);
      chk("li_hi_wdata", obsWdata, 32'h3C081234);
      chk("li_hi_addr", obsAddr, 0);
      chk("li_mid_ready", obsRdy, 0);
      cyc(1, 0);
      chk("li_lo_wdata", obsWdata, 32'h35085678);
      chk("li_lo_addr", obsAddr, 1);
      cyc(0, 1);

      setCmd(24, 1, 2, 0, 0, 32'h00400010);
      cyc(1, 0);
      chk("beq_wdata", obsWdata, 32'h10220003);
      setCmd(30, 0, 0, 0, 0, 32'h00400020);
      cyc(1, 0);
      chk("jal_wdata", obsWdata, 32'h0C100008);
      chk("jal_addr", obsAddr, 1);
      setCmd(24, 1, 2, 0, 0, 32'h00400002);
      cyc(1, 0);
      chk("beq_align_code", obsEc, 2);
      chk("beq_align_we", obsWe, 0);
      setCmd(24, 1, 2, 0, 0, 32'h00500000);
      cyc(1, 0);
      chk("beq_range_code", obsEc, 1);
      chk("beq_range_words", obsWw, 2);

      setCmd(31, 0, 3, 0, 0, 32'hCAFEF00D);
      cyc(1, 0);
      doReset();
      cyc(0, 0);
      chk("rst_mid_li_we", obsWe, 0);

      sel = 1'b1;
      doReset();
      setCmd(1, 4, 5, 6, 0, 32'h0);
      for (int i = 0; i < 4; i++) cyc(1, 0);
      chk("small_full", obsFull, 1);
      chk("small_full_ready", obsRdy, 0);
      cyc(1, 0);
      chk("small_fifth_we", obsWe, 0);
      cyc(0, 1);
      cyc(1, 0);
      chk("after_clear_addr", obsAddr, 0);
      cyc(1, 0);
      cyc(1, 0);
      setCmd(31, 0, 9, 0, 0, 32'h00010002);
      cyc(1, 0);
      chk("li_last_code", obsEc, 4);
      chk("li_last_we", obsWe, 0);
      chk("li_last_words", obsWw, 3);
      setCmd(0, 1, 2, 3, 0, 32'h0);
      cyc(1, 1);
      chk("clear_vs_valid_words", obsWw, 0);

      for (int i = 0; i < 250; i++) begin
         randCmd();
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0);
      end

      sel = 1'b0;
      doReset();
      for (int i = 0; i < 700; i++) begin
         randCmd();
         cyc($urandom_range(0, 9) != 0, (i % 350 == 349) || ($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end
endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Sequential MIPS instruction encoder: accepts decoded instruction commands over a valid/ready handshake and writes the equivalent 32-bit machine words into instruction-memory words. It is the write-side counterpart of the control decoder and produces exactly the OpCode/Funct encodings that the decoder accepts. Typical uses are filling instruction memory in test benches and loading programs at boot. It also computes PC-relative branch offsets and jump indices, expands the `li` pseudo-op into two words, and reports encoding errors.

## Interface
- `ADDR_W`, 8, width of the instruction-memory word address; depth is `2**ADDR_W` words.
- `BASE_ADDR`, 32'h00400000, byte address of memory word 0, used for branch and jump arithmetic.

- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `clear` input 1: synchronous; rewinds the write pointer to 0.
- `cmd_valid` input 1: a command is present.
- `cmd_ready` output 1: the encoder can accept a command.
- `cmd_op` input 5: instruction kind (see Operation).
- `cmd_rs`, `cmd_rt`, `cmd_rd`, `cmd_shamt` input 5 each: register and shift fields.
- `cmd_imm` input 32: immediate value, or the absolute byte target for branches and jumps.
- `imem_we` output 1: write strobe.
- `imem_addr` output ADDR_W: word address of the write.
- `imem_wdata` output 32: encoded instruction word.
- `words_written` output ADDR_W+1: write pointer.
- `full` output 1: `words_written == 2**ADDR_W`.
- `err_valid` output 1: one-cycle error pulse.
- `err_code` output 3: error code; holds its last value between pulses.

## Operation
- `cmd_op` map, R-type (opcode 0, funct given):
  - 0 add 0x20, 1 addu 0x21, 2 sub 0x22, 3 subu 0x23, 4 and 0x24, 5 or 0x25, 6 xor 0x26, 7 nor 0x27, 8 slt 0x2a, 9 sltu 0x2b.
  - 10 sll 0x00, 11 srl 0x02, 12 sra 0x03; these force rs=0.
  - 13 jr 0x08: rt=rd=shamt=0. 14 jalr 0x09: rt=shamt=0.
- `cmd_op` map, I-type (opcode given, imm = `cmd_imm[15:0]`):
  - 15 lui 0x0f: rs=0. 16 addi 0x08, 17 addiu 0x09, 18 andi 0x0c, 19 ori 0x0d, 20 slti 0x0a, 21 sltiu 0x0b, 22 lw 0x23, 23 sw 0x2b.
- `cmd_op` map, branches: 24 beq 0x04, 25 bne 0x05, 26 blez 0x06 (rt=0), 27 bgtz 0x07 (rt=0), 28 bltz 0x01 (rt=0).
- `cmd_op` map, jumps: 29 j 0x02, 30 jal 0x03.
- `cmd_op` 31 is `li`. It emits `lui rt, imm[31:16]`, then `ori rt, rt, imm[15:0]`.
- Branch arithmetic:
  - pc = BASE_ADDR + 4·ptr.
  - diff = cmd_imm − (pc+4), computed in 32-bit two's complement.
  - Offset field = diff[17:2].
  - If `cmd_imm[1:0] != 0`, raise error 2.
  - If diff/4 falls outside [−32768, 32767], raise error 1.
- Jump arithmetic:
  - Index field = cmd_imm[27:2].
  - If `cmd_imm[1:0] != 0`, raise error 2.
  - If `cmd_imm[31:28] != (pc+4)[31:28]`, raise error 3.
- `li` with ptr = 2**ADDR_W − 1: raise error 4.
- On any error: the command is consumed, nothing is written, the pointer is unchanged, and `err_valid` is high for one cycle with the code.
- State machine:
  - IDLE: `cmd_ready = !full && !clear`. An accepted non-`li` command stays in IDLE. An accepted `li` goes to LI_LO.
  - LI_LO: `cmd_ready = 0`; next state is IDLE.
  - An erroring `li` stays in IDLE.
- `clear` takes precedence over acceptance and over the pending LI_LO word. It sets the pointer to 0, sets state to IDLE, drops any pending low word, and leaves `err_code` unchanged.

## Timing
- Reset values:
  - `cmd_ready = 0` in the reset cycle, 1 in the first cycle after.
  - `imem_we = 0`, `imem_addr = 0`, `imem_wdata = 0`.
  - `words_written = 0`, `full = 0`, `err_valid = 0`, `err_code = 0`, state = IDLE.
- Outputs are registered.
- Accept in cycle N: `imem_we`, `imem_addr` (= ptr at N) and `imem_wdata` are valid in cycle N+1. `words_written` increments at N+1.
- Full throughput for non-`li` commands: one word per cycle.
- `li` accepted at N: hi word at N+1 (addr p), lo word at N+2 (addr p+1), `cmd_ready` = 0 at N+1.
- Error accepted at N: `err_valid` = 1 at N+1, `imem_we` = 0.
- `imem_we` is 0 in every cycle without a write; `imem_addr`/`imem_wdata` hold their last values.
- When the pointer reaches 2**ADDR_W, `full` = 1 and `cmd_ready` = 0 from the same cycle. The pointer never wraps; only `clear` or `reset` recovers.
- `reset` mid-`li`: the low word is not written.

## Test plan
- Reset, then add rd=8 rs=9 rt=10 → one cycle later: we=1, addr=0, wdata=0x012A4020, words_written=1.
- li rt=8 imm=0x12345678 at ptr 0 → wdata 0x3C081234 at addr 0, then 0x35085678 at addr 1; cmd_ready=0 in the middle cycle.
- At ptr 0 (BASE 0x00400000):
  - beq rs=1 rt=2 target 0x00400010 → 0x10220003.
  - Then jal target 0x00400020 → 0x0C100008 at addr 1.
- beq target 0x00400002 → err_code 2. beq target 0x00500000 → err_code 1. Neither writes; the pointer is unchanged.
- ADDR_W=2: four back-to-back adds → full=1, cmd_ready=0, and a fifth held-valid command is not accepted. Pulse clear → next add is written at addr 0.
- ADDR_W=2: ptr=3, li → err_code 4, no write. Then clear asserted together with cmd_valid → command not accepted, ptr=0.
